// File: rtl/stat_checker.sv
// stat_checker: decodes a Gray-coded statistic stream and checks that the
// decoded value and the companion event count both advance by exactly one
// per valid sample. The sticky overflow flag is checked against the count.
module stat_checker #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             valid,
  input  logic [WIDTH-1:0] GreyIn,
  input  logic [WIDTH-1:0] CountIn,
  input  logic             OverflowIn,
  output logic [WIDTH-1:0] BinOut,
  output logic             BinValid,
  output logic             SeqError,
  output logic             CountError,
  output logic [7:0]       ErrCount,
  output logic             Locked
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SYNC  = 2'd1;
  localparam logic [1:0] TRACK = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic             bin_valid_q, bin_valid_d;
  logic             seq_err_q, seq_err_d;
  logic             cnt_err_q, cnt_err_d;
  logic [7:0]       err_count_q, err_count_d;
  logic [WIDTH-1:0] ref_bin_q, ref_bin_d;
  logic [WIDTH-1:0] ref_count_q, ref_count_d;
  logic             ref_ovf_q, ref_ovf_d;

  logic [WIDTH-1:0] decoded;
  logic [WIDTH-1:0] exp_bin;
  logic [WIDTH-1:0] exp_count;
  logic             exp_ovf;
  logic             seq_mismatch;
  logic             cnt_mismatch;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
  always_comb begin
    decoded = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      decoded[i] = ^(GreyIn >> i);
    end
  end

  // Expected values derived from the last received sample
  always_comb begin
    exp_bin      = ref_bin_q + WIDTH'(1);
    exp_count    = ref_count_q + WIDTH'(1);
    exp_ovf      = ref_ovf_q | (ref_count_q == '1);
    seq_mismatch = (decoded != exp_bin);
    cnt_mismatch = (CountIn != exp_count) || (OverflowIn != exp_ovf);
  end

  // Next-state logic: clear dominates; decode happens in every state,
  // checking only in TRACK, reference capture in SYNC and TRACK
  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    bin_valid_d = 1'b0;
    seq_err_d   = 1'b0;
    cnt_err_d   = 1'b0;
    err_count_d = err_count_q;
    ref_bin_d   = ref_bin_q;
    ref_count_d = ref_count_q;
    ref_ovf_d   = ref_ovf_q;

    if (clear) begin
      state_d     = IDLE;
      err_count_d = '0;
      ref_bin_d   = '0;
      ref_count_d = '0;
      ref_ovf_d   = 1'b0;
    end else begin
      if (valid) begin
        bin_d       = decoded;
        bin_valid_d = 1'b1;
      end
      case (state_q)
        IDLE: state_d = SYNC;
        SYNC: begin
          if (valid) begin
            ref_bin_d   = decoded;
            ref_count_d = CountIn;
            ref_ovf_d   = OverflowIn;
            state_d     = TRACK;
          end
        end
        TRACK: begin
          if (valid) begin
            seq_err_d = seq_mismatch;
            cnt_err_d = cnt_mismatch;
            if ((seq_mismatch || cnt_mismatch) && (err_count_q != '1)) begin
              err_count_d = err_count_q + 8'd1;
            end
            // Resync to what was received so a single bad sample is
            // flagged at most twice (entering and leaving the glitch)
            ref_bin_d   = decoded;
            ref_count_d = CountIn;
            ref_ovf_d   = OverflowIn;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      bin_valid_q <= 1'b0;
      seq_err_q   <= 1'b0;
      cnt_err_q   <= 1'b0;
      err_count_q <= '0;
      ref_bin_q   <= '0;
      ref_count_q <= '0;
      ref_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      bin_valid_q <= bin_valid_d;
      seq_err_q   <= seq_err_d;
      cnt_err_q   <= cnt_err_d;
      err_count_q <= err_count_d;
      ref_bin_q   <= ref_bin_d;
      ref_count_q <= ref_count_d;
      ref_ovf_q   <= ref_ovf_d;
    end
  end

  assign BinOut     = bin_q;
  assign BinValid   = bin_valid_q;
  assign SeqError   = seq_err_q;
  assign CountError = cnt_err_q;
  assign ErrCount   = err_count_q;
  assign Locked     = (state_q == TRACK);

endmodule

// File: tb/tb_stat_checker.sv
// Testbench for stat_checker: table of directed samples plus hand-written
// sequences for saturation, clear-with-valid and reset mid-stream.
module tb_stat_checker;

  logic       clock;
  logic       reset;
  logic       clear;
  logic       valid;
  logic [7:0] GreyIn;
  logic [7:0] CountIn;
  logic       OverflowIn;
  logic [7:0] BinOut;
  logic       BinValid;
  logic       SeqError;
  logic       CountError;
  logic [7:0] ErrCount;
  logic       Locked;

  int checks = 0;
  int errors = 0;

  stat_checker #(.WIDTH(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear),
    .valid      (valid),
    .GreyIn     (GreyIn),
    .CountIn    (CountIn),
    .OverflowIn (OverflowIn),
    .BinOut     (BinOut),
    .BinValid   (BinValid),
    .SeqError   (SeqError),
    .CountError (CountError),
    .ErrCount   (ErrCount),
    .Locked     (Locked)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       restart;
    logic [7:0] bin;
    logic [7:0] cnt;
    logic       ovf;
    logic       exp_seq;
    logic       exp_cerr;
    logic [7:0] exp_errs;
  } vec_t;

  vec_t vecs[40];
  int   nvec = 0;

  task automatic add(input logic rs, input logic [7:0] b, input logic [7:0] c,
                     input logic o, input logic es, input logic ec,
                     input logic [7:0] ee);
    vecs[nvec].restart  = rs;
    vecs[nvec].bin      = b;
    vecs[nvec].cnt      = c;
    vecs[nvec].ovf      = o;
    vecs[nvec].exp_seq  = es;
    vecs[nvec].exp_cerr = ec;
    vecs[nvec].exp_errs = ee;
    nvec++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drive one cycle of inputs (binary value is Gray-encoded here), then
  // advance past the next rising edge so outputs can be sampled
  task automatic step(input logic v, input logic c, input logic [7:0] b,
                      input logic [7:0] cnt, input logic o);
    valid      = v;
    clear      = c;
    GreyIn     = b ^ (b >> 1);
    CountIn    = cnt;
    OverflowIn = o;
    @(posedge clock);
    #1;
  endtask

  task automatic restart();
    step(1'b0, 1'b1, 8'd0, 8'd0, 1'b0);
    chk("restart_errcount", {24'd0, ErrCount}, 32'd0);
    chk("restart_locked", {31'd0, Locked}, 32'd0);
    step(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    chk("sync_locked", {31'd0, Locked}, 32'd0);
  endtask

  initial begin
    reset      = 1'b0;
    clear      = 1'b0;
    valid      = 1'b0;
    GreyIn     = '0;
    CountIn    = '0;
    OverflowIn = 1'b0;

    // clean stream 0..9
    for (int i = 0; i < 10; i++) add(i == 0, 8'(i), 8'(i), 1'b0, 1'b0, 1'b0, 8'd0);
    // count wrap with overflow set after the wrap
    add(1'b1, 8'd20, 8'hFE, 1'b0, 1'b0, 1'b0, 8'd0);
    add(1'b0, 8'd21, 8'hFF, 1'b0, 1'b0, 1'b0, 8'd0);
    add(1'b0, 8'd22, 8'h00, 1'b1, 1'b0, 1'b0, 8'd0);
    add(1'b0, 8'd23, 8'h01, 1'b1, 1'b0, 1'b0, 8'd0);
    // count wrap with overflow missing: flagged once, then resynced
    add(1'b1, 8'd30, 8'hFE, 1'b0, 1'b0, 1'b0, 8'd0);
    add(1'b0, 8'd31, 8'hFF, 1'b0, 1'b0, 1'b0, 8'd0);
    add(1'b0, 8'd32, 8'h00, 1'b0, 1'b0, 1'b1, 8'd1);
    add(1'b0, 8'd33, 8'h01, 1'b0, 1'b0, 1'b0, 8'd1);
    // Gray glitch 5,6,9,10
    add(1'b1, 8'd5,  8'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    add(1'b0, 8'd6,  8'd1, 1'b0, 1'b0, 1'b0, 8'd0);
    add(1'b0, 8'd9,  8'd2, 1'b0, 1'b1, 1'b0, 8'd1);
    add(1'b0, 8'd10, 8'd3, 1'b0, 1'b0, 1'b0, 8'd1);
    // count skip
    add(1'b1, 8'd50, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    add(1'b0, 8'd51, 8'd5, 1'b0, 1'b0, 1'b1, 8'd1);
    add(1'b0, 8'd52, 8'd6, 1'b0, 1'b0, 1'b0, 8'd1);

    // reset state
    #1;
    chk("reset_binout", {24'd0, BinOut}, 32'd0);
    chk("reset_binvalid", {31'd0, BinValid}, 32'd0);
    chk("reset_locked", {31'd0, Locked}, 32'd0);
    chk("reset_errcount", {24'd0, ErrCount}, 32'd0);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    step(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    chk("post_reset_locked", {31'd0, Locked}, 32'd0);

    // table-driven vectors
    for (int i = 0; i < nvec; i++) begin
      if (vecs[i].restart && i != 0) restart();
      step(1'b1, 1'b0, vecs[i].bin, vecs[i].cnt, vecs[i].ovf);
      chk($sformatf("v%0d_binout", i), {24'd0, BinOut}, {24'd0, vecs[i].bin});
      chk($sformatf("v%0d_binvalid", i), {31'd0, BinValid}, 32'd1);
      chk($sformatf("v%0d_seqerr", i), {31'd0, SeqError}, {31'd0, vecs[i].exp_seq});
      chk($sformatf("v%0d_cnterr", i), {31'd0, CountError}, {31'd0, vecs[i].exp_cerr});
      chk($sformatf("v%0d_errcount", i), {24'd0, ErrCount}, {24'd0, vecs[i].exp_errs});
      chk($sformatf("v%0d_locked", i), {31'd0, Locked}, 32'd1);
    end

    // valid low holds BinOut and drops BinValid
    step(1'b0, 1'b0, 8'd99, 8'd99, 1'b0);
    chk("hold_binout", {24'd0, BinOut}, 32'd52);
    chk("hold_binvalid", {31'd0, BinValid}, 32'd0);
    chk("hold_locked", {31'd0, Locked}, 32'd1);

    // saturation: 300 count mismatches after sync
    restart();
    step(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    for (int i = 1; i <= 300; i++) begin
      step(1'b1, 1'b0, 8'(i), 8'd0, 1'b0);
      if (i == 254) chk("sat_254", {24'd0, ErrCount}, 32'hFE);
      if (i == 255) chk("sat_255", {24'd0, ErrCount}, 32'hFF);
    end
    chk("sat_final", {24'd0, ErrCount}, 32'hFF);
    chk("sat_cnterr", {31'd0, CountError}, 32'd1);
    chk("sat_seqerr", {31'd0, SeqError}, 32'd0);

    // clear together with valid: sample dropped
    step(1'b1, 1'b1, 8'd77, 8'd9, 1'b0);
    chk("clr_binvalid", {31'd0, BinValid}, 32'd0);
    chk("clr_binout", {24'd0, BinOut}, 32'd44);
    chk("clr_locked", {31'd0, Locked}, 32'd0);
    chk("clr_errcount", {24'd0, ErrCount}, 32'd0);
    chk("clr_cnterr", {31'd0, CountError}, 32'd0);
    step(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    chk("clr_sync_locked", {31'd0, Locked}, 32'd0);
    step(1'b1, 1'b0, 8'd77, 8'd9, 1'b0);
    chk("clr_ref_binout", {24'd0, BinOut}, 32'd77);
    chk("clr_ref_errs", {30'd0, SeqError, CountError}, 32'd0);
    chk("clr_ref_locked", {31'd0, Locked}, 32'd1);
    step(1'b1, 1'b0, 8'd78, 8'd10, 1'b0);
    chk("clr_next_errs", {30'd0, SeqError, CountError}, 32'd0);
    chk("clr_next_errcount", {24'd0, ErrCount}, 32'd0);

    // reset mid-stream with an error pending in the counter
    step(1'b1, 1'b0, 8'd80, 8'd11, 1'b0);
    chk("rst_pre_seqerr", {31'd0, SeqError}, 32'd1);
    chk("rst_pre_errcount", {24'd0, ErrCount}, 32'd1);
    valid   = 1'b1;
    GreyIn  = 8'd81 ^ (8'd81 >> 1);
    CountIn = 8'd50;
    #1 reset = 1'b0;
    #1;
    chk("rst_async_binout", {24'd0, BinOut}, 32'd0);
    chk("rst_async_binvalid", {31'd0, BinValid}, 32'd0);
    chk("rst_async_seqerr", {31'd0, SeqError}, 32'd0);
    chk("rst_async_errcount", {24'd0, ErrCount}, 32'd0);
    chk("rst_async_locked", {31'd0, Locked}, 32'd0);
    @(posedge clock);
    #1;
    chk("rst_held_binvalid", {31'd0, BinValid}, 32'd0);
    reset = 1'b1;
    step(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    chk("rst_rel_locked", {31'd0, Locked}, 32'd0);
    chk("rst_rel_errs", {30'd0, SeqError, CountError}, 32'd0);
    step(1'b1, 1'b0, 8'd200, 8'd100, 1'b0);
    chk("rst_relock_locked", {31'd0, Locked}, 32'd1);
    chk("rst_relock_errs", {30'd0, SeqError, CountError}, 32'd0);
    step(1'b1, 1'b0, 8'd201, 8'd101, 1'b0);
    chk("rst_track_binout", {24'd0, BinOut}, 32'd201);
    chk("rst_track_errs", {30'd0, SeqError, CountError}, 32'd0);
    chk("rst_track_errcount", {24'd0, ErrCount}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stat_checker.md
STAT_CHECKER -- requirements
Module: stat_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the data width of the Gray and count inputs.
REQ-002 SHALL have port clock, input, 1 bit: single rising-edge clock for all state.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset, asserted at 0.
REQ-004 SHALL have port clear, input, 1 bit: synchronous restart to IDLE; counters zeroed.
REQ-005 SHALL have port valid, input, 1 bit: GreyIn, CountIn and OverflowIn are sampled this cycle.
REQ-006 SHALL have port GreyIn, input, WIDTH bits: Gray-coded value from the statistic stream.
REQ-007 SHALL have port CountIn, input, WIDTH bits: binary event count from the statistic stream.
REQ-008 SHALL have port OverflowIn, input, 1 bit: sticky overflow flag from the statistic stream.
REQ-009 SHALL have port BinOut, output, WIDTH bits: registered Gray-to-binary decode of GreyIn.
REQ-010 SHALL have port BinValid, output, 1 bit: BinOut and the error flags are valid this cycle.
REQ-011 SHALL have port SeqError, output, 1 bit: one-cycle pulse when the decoded Gray value did not step by exactly +1.
REQ-012 SHALL have port CountError, output, 1 bit: one-cycle pulse on a CountIn step or OverflowIn mismatch.
REQ-013 SHALL have port ErrCount, output, 8 bits: saturating total of flagged samples.
REQ-014 SHALL have port Locked, output, 1 bit: high while in TRACK.

Function
REQ-015 SHALL decode Gray with bit[WIDTH-1] = g[WIDTH-1] and bit[i] = bit[i+1] XOR g[i] for each lower bit.
REQ-016 SHALL register the decode: a sample with valid=1 at edge N gives BinOut and BinValid=1 after edge N+1, a latency of 1.
REQ-017 SHALL hold BinOut and drop BinValid to 0 when valid=0 at the previous edge.
REQ-018 SHALL use three states: IDLE, SYNC and TRACK.
REQ-019 SHALL go IDLE->SYNC on the first edge after reset/clear release; in SYNC the first valid sample is stored as the reference (refBin, refCount, refOvf), no checks are made, and the state goes to TRACK.
REQ-020 SHALL, in TRACK, on each valid sample compute expBin = refBin+1 mod 2^WIDTH and expCount = refCount+1 mod 2^WIDTH.
REQ-021 SHALL set expOvf = refOvf OR (refCount == all-ones), so overflow stays set after the count wraps.
REQ-022 SHALL pulse SeqError when decoded != expBin.
REQ-023 SHALL pulse CountError when CountIn != expCount or OverflowIn != expOvf.
REQ-024 SHALL time both error pulses with the BinValid of the same sample.
REQ-025 SHALL update the reference to the received values (not the expected values) after every checked sample, so one corrupted sample causes at most two flagged samples.
REQ-026 SHALL increment ErrCount by 1 per sample that raises SeqError and/or CountError, saturating at 255 with no wrap.
REQ-027 SHALL make clear=1 dominant over valid in the same cycle: the sample is dropped, state goes to IDLE, ErrCount=0, and no error pulses occur.
REQ-028 SHALL not stall or change state in SYNC or TRACK when valid=0.
REQ-029 SHALL keep Locked=1 exactly while in TRACK.

Reset
REQ-030 SHALL, while reset=0, immediately force state=IDLE, BinOut=0, BinValid=0, SeqError=0, CountError=0, ErrCount=0, Locked=0, and all reference registers to 0.
REQ-031 SHALL abandon any in-flight sample on reset asserted mid-stream, with no error pulse after release.
REQ-032 SHALL take the release of reset synchronously to clock, and SHALL make the first post-release edge perform IDLE->SYNC.

Verification
REQ-033 SHALL cover clean stream: Gray of 0..9 with CountIn 0..9 and OverflowIn=0 -> BinOut 0..9 one cycle later, no error pulses, ErrCount=0, Locked=1 from the second sample.
REQ-034 SHALL cover wrap: CountIn FE, FF, 00, 01 with OverflowIn 0, 0, 1, 1 -> no CountError; the same stream with OverflowIn=0 at 00 -> CountError on that sample and ErrCount=1.
REQ-035 SHALL cover Gray glitch: decoded sequence 5, 6, 9, 10 -> SeqError on 9 only (reference resync), ErrCount=1.
REQ-036 SHALL cover saturation: 300 consecutive count mismatches -> ErrCount stops at FF.
REQ-037 SHALL cover clear with valid: clear=1 and valid=1 on the same edge -> no BinValid, Locked=0, ErrCount=0, and the next valid sample re-enters SYNC unchecked.
REQ-038 SHALL cover reset mid-stream: reset=0 during TRACK -> all outputs 0 at once; after release the stream re-locks with no spurious error.
